// File: rtl/pc_next_gen_pkg.sv
// Shared constants for the fetch-PC generator: counter encodings, branch
// direction constants and default bus width / reset PC.
package pc_next_gen_pkg;

  localparam int          DEFAULT_ADDR_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic BRANCH     = 1'b1;
  localparam logic NOT_BRANCH = 1'b0;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bp_cnt_e;

endpackage

// File: rtl/pc_next_gen_btb_table.sv
// Branch target buffer: direct-mapped storage, combinational lookup,
// synchronous update with 2-bit saturating direction counters.
module btb_table
  import pc_next_gen_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-3:0] lookup_word_i,
  output logic              hit_taken_o,
  output logic [ADDR_W-1:0] hit_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-3:0] upd_word_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [BTB_DEPTH-1:0] valid_r;
  logic [TAG_W-1:0]     tag_r    [BTB_DEPTH];
  logic [ADDR_W-1:0]    target_r [BTB_DEPTH];
  logic [1:0]           cnt_r    [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken == BRANCH) begin
      res = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end else begin
      res = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    end
    return res;
  endfunction

  assign lk_idx_s  = lookup_word_i[IDX_W-1:0];
  assign lk_tag_s  = lookup_word_i[ADDR_W-3:IDX_W];
  assign upd_idx_s = upd_word_i[IDX_W-1:0];
  assign upd_tag_s = upd_word_i[ADDR_W-3:IDX_W];
  assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

  // Reads see pre-update contents; writes land at the clock edge.
  assign hit_taken_o  = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s) && cnt_r[lk_idx_s][1];
  assign hit_target_o = target_r[lk_idx_s];

  // Valid bits: cleared by reset, set on allocation of a taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (upd_valid_i && !upd_hit_s && (upd_taken_i == BRANCH)) begin
      valid_r[upd_idx_s] <= 1'b1;
    end
  end

  // Entry payload: counter training on hit, full overwrite on taken miss.
  always_ff @(posedge clk) begin
    if (upd_valid_i && rst_n) begin
      if (upd_hit_s) begin
        cnt_r[upd_idx_s] <= cnt_next(cnt_r[upd_idx_s], upd_taken_i);
        if (upd_taken_i == BRANCH) begin
          target_r[upd_idx_s] <= upd_target_i;
        end
      end else if (upd_taken_i == BRANCH) begin
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= upd_target_i;
        cnt_r[upd_idx_s]    <= CNT_WT;
      end
    end
  end

endmodule

// File: rtl/pc_next_gen.sv
// Registered fetch PC with flush / mispredict / stall / prediction select.
// Dynamic prediction via btb_table is present only when BTB_EN is defined.
module pc_next_gen
  import pc_next_gen_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter int                BTB_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  input  logic              resolve_valid_i,
  input  logic [ADDR_W-1:0] resolve_pc_i,
  input  logic              resolve_taken_i,
  input  logic [ADDR_W-1:0] resolve_target_i,
  input  logic              mispredict_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_4_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] next_pc_s;
  logic [ADDR_W-1:0] pc_plus_4_s;
  logic [ADDR_W-1:0] redirect_pc_s;
  logic              pred_taken_s;
  logic [ADDR_W-1:0] pred_target_s;

  assign pc_plus_4_s = pc_r + PC_STEP;

`ifdef BTB_EN
  logic              btb_taken_s;
  logic [ADDR_W-1:0] btb_target_s;

  btb_table #(
    .ADDR_W    (ADDR_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_word_i (pc_r[ADDR_W-1:2]),
    .hit_taken_o   (btb_taken_s),
    .hit_target_o  (btb_target_s),
    .upd_valid_i   (resolve_valid_i),
    .upd_word_i    (resolve_pc_i[ADDR_W-1:2]),
    .upd_taken_i   (resolve_taken_i),
    .upd_target_i  (resolve_target_i)
  );

  assign pred_taken_s  = btb_taken_s;
  assign pred_target_s = btb_taken_s ? btb_target_s : pc_plus_4_s;
`else
  // Static not-taken: every taken branch comes back as a mispredict.
  assign pred_taken_s  = 1'b0;
  assign pred_target_s = pc_plus_4_s;
`endif

  // Next-PC priority: flush > mispredict > stall > prediction > sequential.
  always_comb begin
    redirect_pc_s = (resolve_taken_i == BRANCH) ? resolve_target_i : resolve_pc_i + PC_STEP;
    next_pc_s     = pc_plus_4_s;
    if (flush_i) begin
      next_pc_s = flush_addr_i;
    end else if (resolve_valid_i && mispredict_i) begin
      next_pc_s = redirect_pc_s;
    end else if (stall_i) begin
      next_pc_s = pc_r;
    end else if (pred_taken_s) begin
      next_pc_s = pred_target_s;
    end else begin
      next_pc_s = pc_plus_4_s;
    end
  end

  // Architectural fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  assign pc_o          = pc_r;
  assign pc_plus_4_o   = pc_plus_4_s;
  assign pred_taken_o  = pred_taken_s;
  assign pred_target_o = pred_target_s;

endmodule

// File: tb/tb_pc_next_gen.sv
// Self-checking bench for pc_next_gen: directed scenarios plus random traffic
// against a behavioural PC/BTB model. Prediction checks follow BTB_EN.
module tb_pc_next_gen;

  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, resolve_valid_i, resolve_taken_i, mispredict_i;
  logic [31:0] flush_addr_i, resolve_pc_i, resolve_target_i;
  logic [31:0] pc_o, pc_plus_4_o, pred_target_o;
  logic        pred_taken_o;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic [31:0] m_pc;
  bit          m_valid [DEPTH];
  logic [31:0] m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_cnt   [DEPTH];

  pc_next_gen #(.ADDR_W(32), .BTB_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .flush_addr_i     (flush_addr_i),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_pc_i     (resolve_pc_i),
    .resolve_taken_i  (resolve_taken_i),
    .resolve_target_i (resolve_target_i),
    .mispredict_i     (mispredict_i),
    .pc_o             (pc_o),
    .pc_plus_4_o      (pc_plus_4_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit_taken(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % DEPTH);
`ifdef BTB_EN
    return m_valid[i] && (m_tag[i] == (pc >> (2 + IW))) && (m_cnt[i] >= 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
    if (m_hit_taken(pc)) return m_tgt[int'((pc >> 2) % DEPTH)];
    return pc + 32'd4;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // One clock: check current outputs, apply inputs, advance model, wait.
  task automatic cycle(input bit st, input bit fl, input logic [31:0] fa, input bit rv,
                       input logic [31:0] rpc, input bit rt, input logic [31:0] rtg, input bit mp);
    logic [31:0] np;
    logic [31:0] t;
    int          i;
    chk("pc", pc_o, m_pc);
    chk("pc_plus_4", pc_plus_4_o, m_pc + 32'd4);
    chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, m_hit_taken(m_pc)});
    chk("pred_target", pred_target_o, m_pred_target(m_pc));
    stall_i = st; flush_i = fl; flush_addr_i = fa; resolve_valid_i = rv;
    resolve_pc_i = rpc; resolve_taken_i = rt; resolve_target_i = rtg; mispredict_i = mp;
    if (fl)            np = fa;
    else if (rv && mp) np = rt ? rtg : rpc + 32'd4;
    else if (st)       np = m_pc;
    else               np = m_pred_target(m_pc);
`ifdef BTB_EN
    if (rv) begin
      i = int'((rpc >> 2) % DEPTH);
      t = rpc >> (2 + IW);
      if (m_valid[i] && m_tag[i] == t) begin
        m_cnt[i] = rt ? ((m_cnt[i] == 3) ? 3 : m_cnt[i] + 1) : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
        if (rt) m_tgt[i] = rtg;
      end else if (rt) begin
        m_valid[i] = 1'b1; m_tag[i] = t; m_tgt[i] = rtg; m_cnt[i] = 2;
      end
    end
`endif
    m_pc = np;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic flush_to(input logic [31:0] a);
    cycle(1'b0, 1'b1, a, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; flush_addr_i = 32'd0; resolve_valid_i = 1'b0;
    resolve_pc_i = 32'd0; resolve_taken_i = 1'b0; resolve_target_i = 32'd0; mispredict_i = 1'b0;
    m_reset();
    @(negedge clk);
    chk("reset_pc", pc_o, 32'h0000_0000);
    chk("reset_pred_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("reset_pred_target", pred_target_o, 32'h0000_0004);
    @(negedge clk);
    rst_n = 1'b1;

    // free run 0,4,8,C
    for (int k = 0; k < 4; k++) begin
      chk("seq_pc", pc_o, 32'(k * 4));
      chk("seq_pred_taken", {31'd0, pred_taken_o}, 32'd0);
      idle();
    end

    // wrap at top of address space
    flush_to(32'hFFFF_FFFC);
    chk("pre_wrap", pc_o, 32'hFFFF_FFFC);
    idle();
    chk("wrap", pc_o, 32'h0000_0000);

    // stall with flush in second stalled cycle
    flush_to(32'h0000_0010);
    chk("stall_c1", pc_o, 32'h0000_0010);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("stall_c2", pc_o, 32'h0000_0010);
    cycle(1'b1, 1'b1, 32'h80, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("stall_c3", pc_o, 32'h0000_0080);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("stall_hold", pc_o, 32'h0000_0080);
    idle();

    // taken mispredict at 0x20 -> 0x100, then refetch 0x20
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h20, 1'b1, 32'h100, 1'b1);
    chk("mispredict_redirect", pc_o, 32'h0000_0100);
    flush_to(32'h0000_0020);
    chk("refetch_pc", pc_o, 32'h0000_0020);
`ifdef BTB_EN
    chk("btb_alloc_taken", {31'd0, pred_taken_o}, 32'd1);
    chk("btb_alloc_target", pred_target_o, 32'h0000_0100);
`else
    chk("static_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("static_target", pred_target_o, 32'h0000_0024);
`endif
    // two not-taken resolves while stalled on 0x20
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b0);
    chk("train_nt_taken", {31'd0, pred_taken_o}, 32'd0);
    chk("train_nt_target", pred_target_o, 32'h0000_0024);

    // flush beats simultaneous mispredict; BTB still updated
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h40, 1'b1, 32'h300, 1'b1);
    chk("flush_over_mispredict", pc_o, 32'h0000_0200);
    flush_to(32'h0000_0040);
`ifdef BTB_EN
    chk("flush_btb_update", pred_target_o, 32'h0000_0300);
`else
    chk("flush_no_btb", pred_target_o, 32'h0000_0044);
`endif

    // random traffic over a small address window for BTB reuse
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc, fa, rtg;
      rpc = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 9) == 0) rpc = $urandom;
      fa  = 32'($urandom_range(0, 127)) << 2;
      rtg = 32'($urandom_range(0, 127)) << 2;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, fa,
            $urandom_range(0, 9) < 4, rpc, $urandom_range(0, 1) == 1, rtg,
            $urandom_range(0, 2) == 0);
      if (n == 200) begin
        resolve_valid_i = 1'b1; resolve_taken_i = 1'b1; resolve_pc_i = m_pc;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pc", pc_o, 32'h0000_0000);
        chk("midrst_pred", {31'd0, pred_taken_o}, 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_next_gen.md
# pc_next_gen

Parametrised next-PC generator for the fetch stage: holds the architectural fetch PC in a register and each cycle selects the next PC from:

- reset,
- a flush (exception) vector,
- a resolved-branch redirect,
- a stall hold,
- a branch-target-buffer prediction,
- PC+4.

It sits between the pipeline control unit / EX branch resolution and instruction memory. It replaces the purely combinational branch/PC+4 selector with a registered, stall- and flush-aware PC and optional dynamic prediction.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits.
- BTB_DEPTH, 16, BTB entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall_i  in  1  hold PC (fetch stall).
- flush_i  in  1  exception/flush redirect request.
- flush_addr_i  in  ADDR_W  flush target.
- resolve_valid_i  in  1  a branch resolved in EX this cycle.
- resolve_pc_i  in  ADDR_W  PC of the resolved branch.
- resolve_taken_i  in  1  actual direction.
- resolve_target_i  in  ADDR_W  actual taken target.
- mispredict_i  in  1  EX detected wrong prediction; qualified by resolve_valid_i.
- pc_o  out  ADDR_W  current fetch PC (registered).
- pc_plus_4_o  out  ADDR_W  pc_o + 4, combinational.
- pred_taken_o  out  1  prediction for pc_o, combinational.
- pred_target_o  out  ADDR_W  predicted next PC for pc_o, combinational.

## Operation
- next_pc priority, highest first:
  1. flush_i → flush_addr_i.
  2. resolve_valid_i & mispredict_i → resolve_taken_i ? resolve_target_i : resolve_pc_i+4.
  3. stall_i → pc_o (hold).
  4. pred_taken_o → pred_target_o.
  5. Otherwise → pc_plus_4_o.
- Flush and mispredict override stall.
- Arithmetic is modulo 2^ADDR_W: PC+4 wraps all-ones-region to low addresses silently.
- Bits [1:0] are carried through unchanged and not checked.
- BTB entry contents: valid, tag = PC[ADDR_W-1 : 2+log2(BTB_DEPTH)], target, 2-bit saturating counter.
  - Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
  - Index = PC[2+log2(BTB_DEPTH)-1 : 2].
- Lookup on pc_o:
  - Hit = valid & tag match.
  - pred_taken_o = hit & counter[1].
  - pred_target_o = pred_taken_o ? stored target : pc_plus_4_o.
- Update on resolve_valid_i, independent of stall and flush:
  - Tag hit: counter increments if taken, decrements if not taken, saturating at 11/00. The stored target is overwritten with resolve_target_i when taken.
  - Miss and taken: allocate (overwrite) the entry with valid=1, the new tag and target, counter=WT.
  - Miss and not taken: no change.

## Timing
- Reset (async assert, release synchronous to clk):
  - pc_o=RESET_PC.
  - All BTB valid bits = 0, so pred_taken_o=0 and pred_target_o=RESET_PC+4.
  - pc_plus_4_o=RESET_PC+4.
  - Counters and targets need not be reset.
- Reset mid-operation: PC and valid bits clear immediately and any pending update is discarded.
- Redirect latency: a flush or mispredict asserted in cycle N gives pc_o = target in cycle N+1.
- Prediction latency: zero-bubble. Lookup is combinational on pc_o, and the predicted PC appears at the next edge.
- Same-cycle BTB update and lookup on the same index: the lookup sees the pre-update contents (read-before-write). The update becomes visible in the following cycle.
- Stall held for k cycles: pc_o is constant for k cycles. Prediction outputs stay constant unless an update hits the same index.

## Configuration
- BTB_EN defined:
  - BTB storage and prediction are present as described.
- BTB_EN undefined:
  - No BTB storage is instantiated.
  - pred_taken_o=0 and pred_target_o=pc_plus_4_o.
  - Resolve inputs are used only for the mispredict redirect. Every taken branch must therefore arrive as a mispredict (static not-taken).

## Structure
- Shared macros header holds:
  - counter encodings SNT/WNT/WT/ST,
  - the Branch/NotBranch-style control constants,
  - the default reset PC and address bus width defines.
- One sub-module, btb_table, holds the storage array, combinational read port, synchronous update port and counter saturation logic. It is instantiated only under BTB_EN.

## Test plan
- Reset then free-run with no stalls, ADDR_W=32, RESET_PC=0 → pc_o sequence 0,4,8,C; pred_taken_o=0 throughout.
- PC reaches FFFF_FFFC with no redirect → next pc_o=0000_0000.
- stall_i high for 3 cycles at pc 0x10 while flush_i pulses with flush_addr_i=0x80 in cycle 2 → pc_o=0x10,0x10,0x80, then held at 0x80 while stall_i remains high.
- Mispredict on resolve_pc_i=0x20, taken, target 0x100 (BTB_EN) → pc_o=0x100 next cycle. On the next fetch of 0x20, pred_taken_o=1 and pred_target_o=0x100.
- Two not-taken resolves of 0x20 after allocation → counter WT→WNT→SNT. On the next fetch of 0x20, pred_taken_o=0 and pred_target_o=0x24.
- Simultaneous flush_i and mispredict, flush_addr_i=0x200 and resolve_target_i=0x300 → pc_o=0x200, and the BTB update for the resolved branch is still applied.
